// File: rtl/div_unit_pkg.sv
// Shared types for the iterative divider: operation codes and FSM states.
package div_unit_pkg;

  typedef enum logic [1:0] {
    DivOpDiv  = 2'b00,
    DivOpDivu = 2'b01,
    DivOpMod  = 2'b10,
    DivOpModu = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StCalc = 2'b01,
    StFix  = 2'b10,
    StDone = 2'b11
  } div_state_e;

  function automatic logic div_is_signed(input div_op_e op);
    return (op == DivOpDiv) || (op == DivOpMod);
  endfunction

  function automatic logic div_is_mod(input div_op_e op);
    return (op == DivOpMod) || (op == DivOpModu);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem,quo} left, trial-subtract the divisor.
module div_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] i_rem,
  input  logic [XLEN-1:0] i_quo,
  input  logic [XLEN-1:0] i_divisor,
  output logic [XLEN-1:0] o_rem,
  output logic [XLEN-1:0] o_quo
);

  logic [XLEN:0] w_shift;
  logic [XLEN:0] w_trial;

  always_comb begin
    w_shift = {i_rem, i_quo[XLEN-1]};
    w_trial = w_shift - {1'b0, i_divisor};
    if (!w_trial[XLEN]) begin
      o_rem = w_trial[XLEN-1:0];
      o_quo = {i_quo[XLEN-2:0], 1'b1};
    end else begin
      o_rem = w_shift[XLEN-1:0];
      o_quo = {i_quo[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider (DIV/DIVU/MOD/MODU) with valid/ready result handshake.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      div_op,
  input  logic [XLEN-1:0] div_in1,
  input  logic [XLEN-1:0] div_in2,
  input  logic            flush,
  output logic            busy,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] div_out
);

  localparam int unsigned CntW = $clog2(XLEN);

  div_state_e      r_state;
  div_state_e      w_state_nxt;
  div_op_e         r_op;
  logic            r_neg_q;
  logic            r_neg_r;
  logic            r_div_zero;
  logic [XLEN-1:0] r_dvd;
  logic [XLEN-1:0] r_divisor;
  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_quo;
  logic [CntW-1:0] r_cnt;
  logic [XLEN-1:0] r_out;
  logic            r_out_valid;

  div_op_e         w_op;
  logic            w_sgn1;
  logic            w_sgn2;
  logic [XLEN-1:0] w_abs1;
  logic [XLEN-1:0] w_abs2;
  logic [XLEN-1:0] w_rem_nxt;
  logic [XLEN-1:0] w_quo_nxt;
  logic [XLEN-1:0] w_q_fix;
  logic [XLEN-1:0] w_r_fix;
  logic [XLEN-1:0] w_result;

  // Operand sign handling only applies to the signed ops.
  always_comb begin
    w_op   = div_op_e'(div_op);
    w_sgn1 = div_is_signed(w_op) & div_in1[XLEN-1];
    w_sgn2 = div_is_signed(w_op) & div_in2[XLEN-1];
    w_abs1 = w_sgn1 ? (~div_in1 + 1'b1) : div_in1;
    w_abs2 = w_sgn2 ? (~div_in2 + 1'b1) : div_in2;
  end

  div_step #(
    .XLEN(XLEN)
  ) u_div_step (
    .i_rem    (r_rem),
    .i_quo    (r_quo),
    .i_divisor(r_divisor),
    .o_rem    (w_rem_nxt),
    .o_quo    (w_quo_nxt)
  );

  // Zero divisor overrides the datapath result so latency stays uniform.
  always_comb begin
    w_q_fix = r_neg_q ? (~r_quo + 1'b1) : r_quo;
    w_r_fix = r_neg_r ? (~r_rem + 1'b1) : r_rem;
    if (r_div_zero) begin
      w_q_fix = '1;
      w_r_fix = r_dvd;
    end
    w_result = div_is_mod(r_op) ? w_r_fix : w_q_fix;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    busy        = 1'b1;
    unique case (r_state)
      StIdle: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) w_state_nxt = StCalc;
      end
      StCalc: if (r_cnt == CntW'(XLEN - 1)) w_state_nxt = StFix;
      StFix:  w_state_nxt = StDone;
      StDone: if (out_ready) w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
    if (flush) w_state_nxt = StIdle;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= StIdle;
      r_op        <= DivOpDiv;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_div_zero  <= 1'b0;
      r_dvd       <= '0;
      r_divisor   <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_cnt       <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (flush) begin
        r_out_valid <= 1'b0;
        r_cnt       <= '0;
      end else begin
        unique case (r_state)
          StIdle: if (in_valid) begin
            r_op       <= w_op;
            r_neg_q    <= w_sgn1 ^ w_sgn2;
            r_neg_r    <= w_sgn1;
            r_div_zero <= (div_in2 == '0);
            r_dvd      <= div_in1;
            r_divisor  <= w_abs2;
            r_rem      <= '0;
            r_quo      <= w_abs1;
            r_cnt      <= '0;
          end
          StCalc: begin
            r_rem <= w_rem_nxt;
            r_quo <= w_quo_nxt;
            r_cnt <= r_cnt + 1'b1;
          end
          StFix: begin
            r_out       <= w_result;
            r_out_valid <= 1'b1;
          end
          StDone: if (out_ready) r_out_valid <= 1'b0;
          default: ;
        endcase
      end
    end
  end

  assign out_valid = r_out_valid;
  assign div_out   = r_out;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases plus randomized ops vs. arithmetic model.
module tb_div_unit;
  import div_unit_pkg::*;

  // Edges between the accept edge and the first cycle with out_valid high.
  localparam int Lat = 33;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        flush;
  logic        out_ready;
  logic [1:0]  div_op;
  logic [31:0] div_in1;
  logic [31:0] div_in2;
  logic        in_ready;
  logic        busy;
  logic        out_valid;
  logic [31:0] div_out;

  int n_checks = 0;
  int n_errors = 0;

  div_unit #(
    .XLEN(32)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .div_op   (div_op),
    .div_in1  (div_in1),
    .div_in2  (div_in2),
    .flush    (flush),
    .busy     (busy),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .div_out  (div_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: plain arithmetic; SV signed / and % truncate toward zero.
  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa;
    longint sb;
    logic   is_mod;
    logic   is_uns;
    is_mod = (op == DivOpMod) || (op == DivOpModu);
    is_uns = (op == DivOpDivu) || (op == DivOpModu);
    if (b == 32'h0) return is_mod ? a : 32'hFFFF_FFFF;
    if (is_uns) return is_mod ? (a % b) : (a / b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return is_mod ? 32'(sa % sb) : 32'(sa / sb);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int n;
    n = 0;
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
    if (!in_ready) check("accept_timeout", 32'(in_ready), 32'd1);
    div_op   = op;
    div_in1  = a;
    div_in2  = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    div_in1  = $urandom;
    div_in2  = $urandom;
    div_op   = 2'($urandom);
  endtask

  task automatic wait_result(input string tag, input logic [31:0] exp);
    int n;
    n = 0;
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
    check({tag, "_lat"}, 32'(n), 32'(Lat));
    check(tag, div_out, exp);
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b);
    out_ready = 1'b1;
    start_op(op, a, b);
    wait_result(tag, ref_div(op, a, b));
    tick();
  endtask

  logic [1:0]  d_op[10] = '{DivOpDivu, DivOpModu, DivOpDiv, DivOpMod, DivOpMod,
                            DivOpDivu, DivOpModu, DivOpDiv, DivOpMod, DivOpDiv};
  logic [31:0] d_a[10]  = '{32'd100, 32'd100, 32'hFFFF_FF9C, 32'hFFFF_FF9C, 32'd100,
                            32'h1234_5678, 32'h1234_5678, 32'h8000_0000, 32'h8000_0000,
                            32'hFFFF_FF9C};
  logic [31:0] d_b[10]  = '{32'd7, 32'd7, 32'd7, 32'd7, 32'hFFFF_FFF9,
                            32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0};
  logic [31:0] specials[6] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF,
                               32'd7};

  initial begin
    logic [31:0] hold;
    logic        stable;
    logic        seen;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          dly;

    reset     = 1'b1;
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    div_op    = 2'b00;
    div_in1   = '0;
    div_in2   = '0;
    repeat (3) tick();
    reset = 1'b0;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_div_out", div_out, 32'd0);

    for (int i = 0; i < 10; i++) run_op($sformatf("dir%0d", i), d_op[i], d_a[i], d_b[i]);

    // Back-pressure: result held for 10 cycles, then a new op accepted right after handshake.
    out_ready = 1'b0;
    start_op(DivOpDivu, 32'd1000, 32'd33);
    wait_result("bp", 32'd30);
    hold   = div_out;
    stable = 1'b1;
    repeat (10) begin
      tick();
      if (!out_valid || in_ready || div_out !== hold) stable = 1'b0;
    end
    check("bp_stable", 32'(stable), 32'd1);
    out_ready = 1'b1;
    tick();
    check("bp_idle_ready", 32'(in_ready), 32'd1);
    check("bp_idle_valid", 32'(out_valid), 32'd0);
    div_op   = DivOpMod;
    div_in1  = 32'hFFFF_FC18;
    div_in2  = 32'd33;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("bp_next_busy", 32'(busy), 32'd1);
    wait_result("bp_next", ref_div(DivOpMod, 32'hFFFF_FC18, 32'd33));
    hold = div_out;
    tick();

    // Flush at count 15 with a competing in_valid.
    start_op(DivOpDivu, 32'd5000, 32'd3);
    repeat (15) tick();
    flush    = 1'b1;
    in_valid = 1'b1;
    div_op   = DivOpDivu;
    div_in1  = 32'd77;
    div_in2  = 32'd7;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("fl_busy", 32'(busy), 32'd0);
    check("fl_in_ready", 32'(in_ready), 32'd1);
    check("fl_div_out", div_out, hold);
    seen = 1'b0;
    repeat (40) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    check("fl_no_valid", 32'(seen), 32'd0);
    run_op("fl_after", DivOpDivu, 32'd9, 32'd3);

    // Reset at count 20.
    start_op(DivOpDiv, 32'hFFFF_0000, 32'd5);
    repeat (20) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mrst_in_ready", 32'(in_ready), 32'd1);
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_out_valid", 32'(out_valid), 32'd0);
    check("mrst_div_out", div_out, 32'd0);
    run_op("mrst_after", DivOpDivu, 32'hFFFF_FFFF, 32'd1);

    // Randomized ops with random consumer delay.
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom);
      a  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
      b  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)]
                                       : ($urandom >> $urandom_range(0, 31));
      dly = $urandom_range(0, 3);
      out_ready = (dly == 0);
      start_op(op, a, b);
      wait_result($sformatf("rnd%0d", i), ref_div(op, a, b));
      repeat (dly) tick();
      out_ready = 1'b1;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
